// File: rtl/mult_div_if.sv
// rtl/mult_div_if.sv - request/result bundle between the issue stage and the mult/div unit
interface mult_div_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic [WIDTH-1:0] HiWriteData;
    logic [WIDTH-1:0] LoWriteData;
    logic             HiWriteEnable;
    logic             LoWriteEnable;
    logic             DivZero;

    modport master (
        output Start, Op, A, B,
        input  Busy, HiWriteData, LoWriteData, HiWriteEnable, LoWriteEnable, DivZero
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, HiWriteData, LoWriteData, HiWriteEnable, LoWriteEnable, DivZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit signed/unsigned multiply and divide producing Hi/Lo writes
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic        Clk,
    input logic        Reset,
    mult_div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t               state, nextState;
    logic [CW-1:0]        count;
    logic [1:0]           opReg;
    logic [WIDTH-1:0]     aReg;
    logic [WIDTH-1:0]     bMag;
    logic                 aNeg, bNeg;
    logic [2*WIDTH-1:0]   acc;

    logic                 isDiv, isSigned;
    logic                 aNegIn, bNegIn;
    logic [WIDTH-1:0]     aMagIn, bMagIn;
    logic [WIDTH:0]       multSum;
    logic [WIDTH:0]       divCand;
    logic                 divOk;
    logic [WIDTH-1:0]     divRem;
    logic [2*WIDTH-1:0]   iterNext;
    logic [2*WIDTH-1:0]   prodRes;
    logic [WIDTH-1:0]     quotRes, remRes;

    assign isDiv    = opReg[1];
    assign isSigned = ~opReg[0];

    assign aNegIn = ~bus.Op[0] & bus.A[WIDTH-1];
    assign bNegIn = ~bus.Op[0] & bus.B[WIDTH-1];
    assign aMagIn = aNegIn ? -bus.A : bus.A;
    assign bMagIn = bNegIn ? -bus.B : bus.B;

    // Multiply shifts the product right through acc; divide shifts the dividend left into the remainder half.
    always_comb begin
        multSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bMag} : '0);
        divCand  = acc[2*WIDTH-1:WIDTH-1];
        divOk    = divCand >= {1'b0, bMag};
        divRem   = divCand[WIDTH-1:0] - bMag;
        iterNext = acc;
        if (isDiv) begin
            if (divOk)
                iterNext = {divRem, acc[WIDTH-2:0], 1'b1};
            else
                iterNext = {divCand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            iterNext = {multSum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prodRes = (isSigned && (aNeg ^ bNeg)) ? -acc : acc;
        quotRes = (isSigned && (aNeg ^ bNeg)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remRes  = (isSigned && aNeg) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.Start) nextState = ITER;
            ITER:    if (count == CW'(WIDTH - 1)) nextState = FIXUP;
            FIXUP:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count             <= '0;
            opReg             <= '0;
            aReg              <= '0;
            bMag              <= '0;
            aNeg              <= 1'b0;
            bNeg              <= 1'b0;
            acc               <= '0;
            bus.Busy          <= 1'b0;
            bus.HiWriteEnable <= 1'b0;
            bus.LoWriteEnable <= 1'b0;
            bus.DivZero       <= 1'b0;
            bus.HiWriteData   <= '0;
            bus.LoWriteData   <= '0;
        end else begin
            bus.Busy          <= nextState != IDLE;
            bus.HiWriteEnable <= nextState == DONE;
            bus.LoWriteEnable <= nextState == DONE;
            bus.DivZero       <= (state == FIXUP) && isDiv && (bMag == '0);
            case (state)
                IDLE: if (bus.Start) begin
                    opReg <= bus.Op;
                    aReg  <= bus.A;
                    aNeg  <= aNegIn;
                    bNeg  <= bNegIn;
                    bMag  <= bMagIn;
                    acc   <= {{WIDTH{1'b0}}, aMagIn};
                    count <= '0;
                end
                ITER: begin
                    acc   <= iterNext;
                    count <= count + 1'b1;
                end
                FIXUP: begin
                    if (!isDiv) begin
                        bus.HiWriteData <= prodRes[2*WIDTH-1:WIDTH];
                        bus.LoWriteData <= prodRes[WIDTH-1:0];
                    end else if (bMag == '0) begin
                        bus.HiWriteData <= aReg;
                        bus.LoWriteData <= '1;
                    end else begin
                        bus.HiWriteData <= remRes;
                        bus.LoWriteData <= quotRes;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          edgeNo;
    } exp_t;

    exp_t expQ[$];

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          q, r;
        case (op)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {1'b0, r, q};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Drive at a falling edge; the request is accepted on the next rising edge.
    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [64:0] exp, input bit push, output int acceptEdge);
        exp_t e;
        bus.Start  = 1'b1;
        bus.Op     = op;
        bus.A      = a;
        bus.B      = b;
        acceptEdge = cyc + 1;
        if (push) begin
            e.dz = exp[64]; e.hi = exp[63:32]; e.lo = exp[31:0]; e.edgeNo = acceptEdge + 33;
            expQ.push_back(e);
        end
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.Op    = 2'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
        checkValue("busy_after_accept", 64'(bus.Busy), 64'd1);
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.Busy) begin done = 1; break; end
            @(negedge Clk);
        end
        if (!done) checkValue("idle_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (bus.HiWriteEnable) begin
            if (expQ.size() == 0) begin
                checkValue("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkValue("strobe_cycle", 64'(cyc), 64'(e.edgeNo));
                checkValue("lo_enable", 64'(bus.LoWriteEnable), 64'd1);
                checkValue("hi_data", 64'(bus.HiWriteData), 64'(e.hi));
                checkValue("lo_data", 64'(bus.LoWriteData), 64'(e.lo));
                checkValue("div_zero", 64'(bus.DivZero), 64'(e.dz));
            end
        end else if (bus.LoWriteEnable || bus.DivZero) begin
            checkValue("stray_lo_or_dz", {62'd0, bus.LoWriteEnable, bus.DivZero}, 64'd0);
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] hi, lo;
        logic        dz;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   k, k2;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        Reset = 1'b1; bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge Clk);
        checkValue("reset_busy", 64'(bus.Busy), 64'd0);
        checkValue("reset_strobes", {62'd0, bus.HiWriteEnable, bus.LoWriteEnable}, 64'd0);
        checkValue("reset_dz", 64'(bus.DivZero), 64'd0);
        checkValue("reset_data", {bus.HiWriteData, bus.LoWriteData}, 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        vecs.push_back('{2'b00, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
        vecs.push_back('{2'b00, 32'd0,        32'h80000000, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
        vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0});
        vecs.push_back('{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1});
        vecs.push_back('{2'b10, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1});
        foreach (vecs[i]) begin
            startOp(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].dz, vecs[i].hi, vecs[i].lo}, 1'b1, k);
            waitIdle();
            @(negedge Clk);
        end

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 1000)));
            startOp(rop, ra, rb, model(rop, ra, rb), 1'b1, k);
            waitIdle();
            @(negedge Clk);
        end

        // Abort an in-flight divide with Reset; an extra Start mid-flight must be ignored.
        startOp(2'b11, 32'd100, 32'd7, '0, 1'b0, k);
        while (cyc < k + 4) @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 2'b01; bus.A = 32'd1; bus.B = 32'd1;
        @(negedge Clk);
        bus.Start = 1'b0;
        checkValue("busy_ignored_start", 64'(bus.Busy), 64'd1);
        while (cyc < k + 9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checkValue("abort_busy", 64'(bus.Busy), 64'd0);
        checkValue("abort_data", {bus.HiWriteData, bus.LoWriteData}, 64'd0);
        repeat (30) @(negedge Clk);
        checkValue("abort_no_pending", 64'(expQ.size()), 64'd0);
        startOp(2'b01, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12}, 1'b1, k);
        waitIdle();
        @(negedge Clk);

        // Back-to-back: second Start in the first IDLE cycle after DONE.
        startOp(2'b01, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6}, 1'b1, k);
        for (int i = 0; i < 60 && !bus.HiWriteEnable; i++) @(negedge Clk);
        @(negedge Clk);
        startOp(2'b11, 32'd9, 32'd2, {1'b0, 32'd1, 32'd4}, 1'b1, k2);
        checkValue("b2b_spacing", 64'(k2 - k), 64'd35);
        waitIdle();
        repeat (3) @(negedge Clk);
        checkValue("final_busy", 64'(bus.Busy), 64'd0);
        checkValue("queue_drained", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, synchronous active-high reset sampled on the rising edge of Clk.
REQ-004 The block SHALL have port Start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port Op, input, 2, operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 The block SHALL have port A, input, 32, multiplicand or dividend (rs).
REQ-007 The block SHALL have port B, input, 32, multiplier or divisor (rt).
REQ-008 The block SHALL have port Busy, output, 1, high from acceptance through the DONE cycle.
REQ-009 The block SHALL have port HiWriteData, output, 32, product[63:32] or remainder; drives the Hi/Lo register file.
REQ-010 The block SHALL have port LoWriteData, output, 32, product[31:0] or quotient.
REQ-011 The block SHALL have ports HiWriteEnable and LoWriteEnable, output, 1 each, one-cycle write strobes to the Hi/Lo register file.
REQ-012 The block SHALL have port DivZero, output, 1, pulses with the strobes when a divide had B==0.

Function
REQ-013 The FSM SHALL have states IDLE, ITER, FIXUP and DONE; all outputs are registered.
REQ-014 In IDLE with Start=1 at edge k: latch Op, A and B; record operand signs; for signed ops latch magnitudes; set count=0; go to ITER.
REQ-015 ITER SHALL process one bit per cycle: shift-add for multiply, restoring subtract for divide; exactly 32 iterations (edges k+1..k+32); then go to FIXUP.
REQ-016 FIXUP (edge k+33) SHALL negate the 64-bit product when signed and the operand signs differ; negate the quotient when signed and the signs differ; give the remainder the sign of the dividend; load HiWriteData and LoWriteData; go to DONE.
REQ-017 In DONE, HiWriteEnable and LoWriteEnable SHALL both be 1 for exactly that one cycle, so the Hi/Lo file captures at edge k+34; DONE then returns to IDLE.
REQ-018 Busy SHALL be 1 in ITER, FIXUP and DONE, and 0 in IDLE.
REQ-019 Start SHALL be ignored while Busy=1; a new Start is accepted in the first IDLE cycle after DONE.
REQ-020 Changes on A, B or Op after acceptance SHALL NOT affect the result.
REQ-021 Divide by zero (DIV or DIVU): Lo=32'hFFFFFFFF, Hi=A as latched; DivZero=1 during DONE only; latency unchanged.
REQ-022 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL yield Lo=32'h80000000, Hi=0, with no flag.
REQ-023 HiWriteData and LoWriteData SHALL hold the last result until the next FIXUP.
REQ-024 The enables SHALL be 0 in all states other than DONE.

Reset
REQ-025 On Reset=1 at an edge: state=IDLE, Busy=0, HiWriteEnable=0, LoWriteEnable=0, DivZero=0, HiWriteData=0, LoWriteData=0, count=0.
REQ-026 Reset SHALL take priority over Start and over any in-flight operation; an aborted operation produces no write strobe.

Verification
REQ-027 MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF, Start at edge k: strobes high exactly in cycle k+33..k+34 with Hi=32'hFFFFFFFE, Lo=32'h00000001; Busy low after.
REQ-028 MULT A=-7 (32'hFFFFFFF9), B=3: Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB. Also MULT 0 x 32'h80000000: Hi=0, Lo=0.
REQ-029 DIV A=-7, B=2: Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF. DIVU A=100, B=7: Lo=14, Hi=2. DIV 32'h80000000 / 32'hFFFFFFFF: Lo=32'h80000000, Hi=0.
REQ-030 DIVU A=5, B=0: Lo=32'hFFFFFFFF, Hi=5, DivZero=1 for one cycle coincident with the strobes.
REQ-031 Start DIVU 100/7, then pulse Start with A=1, B=1 at k+5 (ignored) and assert Reset at k+10: no strobe occurs; Busy=0 from k+11; data outputs=0; a fresh MULTU 3x4 then gives Lo=12, Hi=0 at the expected latency.
REQ-032 Back-to-back: MULTU 2x3, then Start with DIVU 9/2 in the first IDLE cycle: two strobe pulses 35 cycles apart; results Lo=6, Hi=0 then Lo=4, Hi=1.
